// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, instruction field positions and the
// source/destination decode used by issue, execute and writeback.
package cpu_pkg;

  localparam int unsigned REG_WIDTH_DEF = 8;
  localparam int unsigned REG_COUNT_DEF = 8;
  localparam int unsigned INSTR_W       = 16;
  localparam int unsigned OP_W          = 4;

  // Instruction field bit positions
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_MSB = 8;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_MSB = 5;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OP_W-1:0] OP_AND  = 4'h3;
  localparam logic [OP_W-1:0] OP_OR   = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h5;
  localparam logic [OP_W-1:0] OP_LDI  = 4'h6;
  localparam logic [OP_W-1:0] OP_MOV  = 4'h7;
  localparam logic [OP_W-1:0] OP_SHL  = 4'h8;
  localparam logic [OP_W-1:0] OP_SHR  = 4'h9;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  // Operand A source selection
  typedef enum logic [1:0] {
    SrcZero,
    SrcRs1,
    SrcImm
  } a_sel_e;

  // Opcodes 0xA..0xE have no meaning; they travel down the pipe as NOPs.
  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

  function automatic logic uses_rs1(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_MOV, OP_SHL, OP_SHR: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic uses_rs2(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic writes_rd(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_LDI, OP_MOV, OP_SHL, OP_SHR: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic a_sel_e a_sel(input logic [OP_W-1:0] op);
    a_sel_e r;
    if (op == OP_LDI) begin
      r = SrcImm;
    end else if (uses_rs1(op)) begin
      r = SrcRs1;
    end else begin
      r = SrcZero;
    end
    return r;
  endfunction

endpackage

// File: rtl/issue_stage_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writing instruction issues and cleared by its writeback. Answers a
// three-address hazard query against the registered bits only.
module issue_stage_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned REG_COUNT = REG_COUNT_DEF,
  localparam int unsigned AW = $clog2(REG_COUNT)
) (
  input  logic          clk,
  input  logic          rst,
  // Issue side: mark a destination pending
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  // Writeback side: retire a pending destination
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  // Hazard query
  input  logic          q_rs1_en,
  input  logic [AW-1:0] q_rs1,
  input  logic          q_rs2_en,
  input  logic [AW-1:0] q_rs2,
  input  logic          q_rd_en,
  input  logic [AW-1:0] q_rd,
  output logic          hazard
);

  logic [REG_COUNT-1:0] pend_d, pend_q;

  // Next pending set: clear first so a same-register set overrides it
  always_comb begin
    pend_d = pend_q;
    if (clr_en) begin
      pend_d[clr_addr] = 1'b0;
    end
    if (set_en) begin
      pend_d[set_addr] = 1'b1;
    end
  end

  // Pending bits; writebacks seen during reset are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // No bypass: a writeback landing this cycle still reports a hazard
  always_comb begin
    hazard = (q_rs1_en & pend_q[q_rs1]) |
             (q_rs2_en & pend_q[q_rs2]) |
             (q_rd_en  & pend_q[q_rd]);
  end

endmodule

// File: rtl/issue_stage.sv
// Decode/issue stage in front of the register file. Decodes 16-bit
// instructions, reads operands asynchronously, stalls on pending writes and
// hands a registered packet to execute over a valid/ready handshake.
module issue_stage
  import cpu_pkg::*;
#(
  parameter int unsigned REG_WIDTH = REG_WIDTH_DEF,
  parameter int unsigned REG_COUNT = REG_COUNT_DEF,
  localparam int unsigned AW = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  // Instruction input
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  // Register-file read ports
  output logic [AW-1:0]        rf_rd_addr1,
  output logic [AW-1:0]        rf_rd_addr2,
  input  logic [REG_WIDTH-1:0] rf_rd_data1,
  input  logic [REG_WIDTH-1:0] rf_rd_data2,
  // Issue packet to execute
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_W-1:0]      out_op,
  output logic [AW-1:0]        out_rd,
  output logic [REG_WIDTH-1:0] out_a,
  output logic [REG_WIDTH-1:0] out_b,
  output logic                 out_we,
  output logic                 out_illegal,
  // Writeback notification
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_addr,
  output logic                 halted
);

  // Instruction fields
  logic [OP_W-1:0] op;
  logic [AW-1:0]   rd, rs1, rs2;
  logic [7:0]      imm8;

  assign op   = in_instr[OP_MSB:OP_LSB];
  assign rd   = in_instr[RD_MSB:RD_LSB];
  assign rs1  = in_instr[RS1_MSB:RS1_LSB];
  assign rs2  = in_instr[RS2_MSB:RS2_LSB];
  assign imm8 = in_instr[IMM_MSB:IMM_LSB];

  assign rf_rd_addr1 = rs1;
  assign rf_rd_addr2 = rs2;

  // Decode
  logic   dec_rs1, dec_rs2, dec_we, dec_illegal, dec_halt;
  a_sel_e dec_a_sel;

  always_comb begin
    dec_rs1     = uses_rs1(op);
    dec_rs2     = uses_rs2(op);
    dec_we      = writes_rd(op);
    dec_illegal = is_illegal(op);
    dec_halt    = (op == OP_HALT);
    dec_a_sel   = a_sel(op);
  end

  // Packet and status state
  logic                 out_valid_d, out_valid_q;
  logic [OP_W-1:0]      out_op_d, out_op_q;
  logic [AW-1:0]        out_rd_d, out_rd_q;
  logic [REG_WIDTH-1:0] out_a_d, out_a_q;
  logic [REG_WIDTH-1:0] out_b_d, out_b_q;
  logic                 out_we_d, out_we_q;
  logic                 out_illegal_d, out_illegal_q;
  logic                 halted_d, halted_q;

  logic hazard;
  logic accept;

  issue_stage_scoreboard #(
    .REG_COUNT (REG_COUNT)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept & dec_we),
    .set_addr (rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .q_rs1_en (dec_rs1),
    .q_rs1    (rs1),
    .q_rs2_en (dec_rs2),
    .q_rs2    (rs2),
    .q_rd_en  (dec_we),
    .q_rd     (rd),
    .hazard   (hazard)
  );

  // Handshake: accept only when not halted, hazard-free and the output slot frees up
  always_comb begin
    in_ready = ~halted_q & ~hazard & (~out_valid_q | out_ready);
    accept   = in_valid & in_ready;
  end

  // Next packet: load on accept, drop when consumed, otherwise hold
  always_comb begin
    out_valid_d   = out_valid_q;
    out_op_d      = out_op_q;
    out_rd_d      = out_rd_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_we_d      = out_we_q;
    out_illegal_d = out_illegal_q;
    halted_d      = halted_q;

    if (accept) begin
      out_valid_d   = 1'b1;
      out_op_d      = op;
      out_rd_d      = rd;
      out_we_d      = dec_we;
      out_illegal_d = dec_illegal;
      unique case (dec_a_sel)
        SrcRs1:  out_a_d = rf_rd_data1;
        SrcImm:  out_a_d = REG_WIDTH'(imm8);
        default: out_a_d = '0;
      endcase
      out_b_d = dec_rs2 ? rf_rd_data2 : '0;
      if (dec_halt) begin
        halted_d = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Packet registers; reset discards any held packet
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_op_q      <= '0;
      out_rd_q      <= '0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_we_q      <= 1'b0;
      out_illegal_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_op_q      <= out_op_d;
      out_rd_q      <= out_rd_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_we_q      <= out_we_d;
      out_illegal_q <= out_illegal_d;
      halted_q      <= halted_d;
    end
  end

  // Outputs
  always_comb begin
    out_valid   = out_valid_q;
    out_op      = out_op_q;
    out_rd      = out_rd_q;
    out_a       = out_a_q;
    out_b       = out_b_q;
    out_we      = out_we_q;
    out_illegal = out_illegal_q;
    halted      = halted_q;
  end

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: a small register-file model feeds the read ports,
// a scoreboard queue predicts every issued packet, and per-scenario tasks
// check handshake, stall, hold, halt and reset behaviour.
module tb_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [2:0]  rf_rd_addr1, rf_rd_addr2;
  logic [7:0]  rf_rd_data1, rf_rd_data2;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [2:0]  out_rd;
  logic [7:0]  out_a, out_b;
  logic        out_we;
  logic        out_illegal;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        halted;

  int total = 0;
  int bad   = 0;

  issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .rf_rd_addr1 (rf_rd_addr1),
    .rf_rd_addr2 (rf_rd_addr2),
    .rf_rd_data1 (rf_rd_data1),
    .rf_rd_data2 (rf_rd_data2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_rd      (out_rd),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_we      (out_we),
    .out_illegal (out_illegal),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: written on the writeback edge, read asynchronously
  logic [7:0] rf [8];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= (i == 2) ? 8'h05 : 8'(8'h10 + i);
    end else if (wb_valid) begin
      rf[wb_addr] <= wb_data;
    end
  end
  assign rf_rd_data1 = rf[rf_rd_addr1];
  assign rf_rd_data2 = rf[rf_rd_addr2];

  // Packet = {valid, op, rd, a, b, we, illegal}
  typedef logic [25:0] pkt_t;
  pkt_t exp_q[$];
  logic exp_due = 1'b0;

  function automatic pkt_t model(input logic [15:0] ins);
    logic [3:0] op;
    logic [7:0] a, b;
    logic       we, ill;
    op = ins[15:12];
    a = 8'h00; b = 8'h00; we = 1'b0; ill = 1'b0;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        a = rf[ins[8:6]]; b = rf[ins[5:3]]; we = 1'b1;
      end
      4'h6:             begin a = ins[7:0]; we = 1'b1; end
      4'h7, 4'h8, 4'h9: begin a = rf[ins[8:6]]; we = 1'b1; end
      4'h0, 4'hF:       ;
      default:          ill = 1'b1;
    endcase
    return {1'b1, op, ins[11:9], a, b, we, ill};
  endfunction

  // Predict at mid-cycle (inputs stable), compare one cycle after the accept edge
  always @(negedge clk) begin
    pkt_t got, exp;
    if (rst) begin
      exp_due = 1'b0;
      exp_q.delete();
    end else begin
      if (exp_due) begin
        got = {out_valid, out_op, out_rd, out_a, out_b, out_we, out_illegal};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL packet: got=%h want=%h", got, exp);
        end
      end
      exp_due = in_valid && in_ready;
      if (exp_due) exp_q.push_back(model(in_instr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins);
    in_valid = v;
    in_instr = ins;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    total++;
    if ({out_valid, out_op, out_rd, out_a, out_b, out_we, out_illegal, halted} !== 27'd0) begin
      bad++; $display("FAIL reset_outputs: got=%h want=0",
        {out_valid, out_op, out_rd, out_a, out_b, out_we, out_illegal, halted});
    end
    total++;
    if (dut.u_sb.pend_q !== 8'h00) begin
      bad++; $display("FAIL reset_pend: got=%h want=00", dut.u_sb.pend_q);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got=%b want=1", in_ready); end
  endtask

  task automatic test_ldi();
    cyc();
    drive(1'b1, 16'h622A);               // LDI r1,0x2A
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL ldi_ready: got=%b want=1", in_ready); end
    cyc();
    drive(1'b0, 16'h0000);
    #1;
    total++;
    if ({out_valid, out_op, out_rd, out_a, out_b, out_we} !== {1'b1, 4'h6, 3'd1, 8'h2A, 8'h00, 1'b1}) begin
      bad++; $display("FAIL ldi_packet: got=%h", {out_valid, out_op, out_rd, out_a, out_b, out_we});
    end
    total++;
    if (dut.u_sb.pend_q[1] !== 1'b1) begin bad++; $display("FAIL ldi_pend1: got=0 want=1"); end
  endtask

  task automatic test_raw();
    cyc();
    drive(1'b1, 16'h1650);               // ADD r3,r1,r2
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL raw_stall0: got=%b want=0", in_ready); end
    cyc();
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL raw_stall1: got=%b want=0", in_ready); end
    wb_valid = 1'b1; wb_addr = 3'd1; wb_data = 8'h2A;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL raw_no_bypass: got=%b want=0", in_ready); end
    cyc();
    wb_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL raw_release: got=%b want=1", in_ready); end
    cyc();
    drive(1'b0, 16'h0000);
    #1;
    total++;
    if ({out_op, out_a, out_b} !== {4'h1, 8'h2A, 8'h05}) begin
      bad++; $display("FAIL raw_operands: got=%h want=12a05", {out_op, out_a, out_b});
    end
  endtask

  task automatic test_hold();
    cyc();
    out_ready = 1'b0;
    drive(1'b1, 16'h2970);               // SUB r4,r5,r6
    cyc();
    drive(1'b1, 16'h5E00);               // XOR r7,r0,r0 waits behind it
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if ({out_valid, out_op, out_rd, out_a, out_b, out_we, in_ready} !==
          {1'b1, 4'h2, 3'd4, 8'h15, 8'h16, 1'b1, 1'b0}) begin
        bad++; $display("FAIL hold_cycle%0d: got=%h", k,
          {out_valid, out_op, out_rd, out_a, out_b, out_we, in_ready});
      end
      cyc();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release: got=%b want=1", in_ready); end
    cyc();
    drive(1'b0, 16'h0000);
    #1;
    total++;
    if ({out_op, out_rd} !== {4'h5, 3'd7}) begin
      bad++; $display("FAIL hold_replace: got=%h want=2f", {out_op, out_rd});
    end
  endtask

  task automatic test_illegal();
    cyc();
    drive(1'b1, 16'hCA00);               // undefined opcode 0xC, rd=5
    cyc();
    drive(1'b0, 16'h0000);
    #1;
    total++;
    if ({out_valid, out_op, out_illegal, out_we} !== {1'b1, 4'hC, 1'b1, 1'b0}) begin
      bad++; $display("FAIL illegal_packet: got=%h", {out_valid, out_op, out_illegal, out_we});
    end
    total++;
    if (dut.u_sb.pend_q[5] !== 1'b0) begin bad++; $display("FAIL illegal_pend5: got=1 want=0"); end
  endtask

  task automatic test_set_wins();
    cyc();
    drive(1'b1, 16'h6477);               // LDI r2,0x77 with same-cycle wb r2
    wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 8'h55;
    cyc();
    wb_valid = 1'b0;
    drive(1'b1, 16'h7080);               // MOV r0,r2
    #1;
    total++;
    if (dut.u_sb.pend_q[2] !== 1'b1) begin bad++; $display("FAIL setwins_pend2: got=0 want=1"); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL setwins_stall: got=%b want=0", in_ready); end
    wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 8'h66;
    cyc();
    wb_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL setwins_release: got=%b want=1", in_ready); end
    cyc();
    drive(1'b0, 16'h0000);
    #1;
    total++;
    if ({out_op, out_a} !== {4'h7, 8'h66}) begin
      bad++; $display("FAIL setwins_mov: got=%h want=766", {out_op, out_a});
    end
  endtask

  task automatic test_halt();
    cyc();
    drive(1'b1, 16'hF000);
    cyc();
    drive(1'b1, 16'h0000);               // keep offering NOPs
    #1;
    total++;
    if ({halted, out_valid, out_op, out_we} !== {1'b1, 1'b1, 4'hF, 1'b0}) begin
      bad++; $display("FAIL halt_packet: got=%h", {halted, out_valid, out_op, out_we});
    end
    for (int k = 0; k < 10; k++) begin
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL halt_blocked%0d: got=1 want=0", k); end
      cyc();
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL halt_drain: got=1 want=0"); end
    drive(1'b0, 16'h0000);
  endtask

  task automatic test_back_to_back_reset();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    total++;
    if ({in_ready, halted} !== 2'b10) begin
      bad++; $display("FAIL rst_unhalt: got=%b want=10", {in_ready, halted});
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, {4'h6, 3'(i), 1'b0, 8'(8'hA0 + i)});
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got=0 want=1", i); end
      cyc();
    end
    drive(1'b0, 16'h0000);
    out_ready = 1'b0;
    #1;
    total++;
    if ({dut.u_sb.pend_q, out_valid, out_rd, out_a} !== {8'hFF, 1'b1, 3'd7, 8'hA7}) begin
      bad++; $display("FAIL b2b_state: got=%h", {dut.u_sb.pend_q, out_valid, out_rd, out_a});
    end
    cyc();
    rst = 1'b1;
    wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 8'hEE;
    cyc();
    rst = 1'b0;
    wb_valid = 1'b0;
    #1;
    total++;
    if ({out_valid, out_op, out_rd, out_a, out_b, out_we, out_illegal, halted} !== 27'd0) begin
      bad++; $display("FAIL midrst_outputs: got=%h want=0",
        {out_valid, out_op, out_rd, out_a, out_b, out_we, out_illegal, halted});
    end
    total++;
    if ({dut.u_sb.pend_q, in_ready} !== 9'h001) begin
      bad++; $display("FAIL midrst_pend_ready: got=%h want=001", {dut.u_sb.pend_q, in_ready});
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 16'h0000;
    out_ready = 1'b1;
    wb_valid = 1'b0;
    wb_addr = 3'd0;
    wb_data = 8'h00;
    test_reset();
    test_ldi();
    test_raw();
    test_hold();
    test_illegal();
    test_set_wins();
    test_halt();
    test_back_to_back_reset();
    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Decode/issue stage directly upstream of the 8x8 register file.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Drives the register-file read addresses and captures the asynchronous read data into a registered issue packet for execute.
- A pending-write scoreboard stalls on RAW/WAW hazards until the matching writeback completes.

Parameters:
- REG_WIDTH, 8, data width of operands and register file.
- REG_COUNT, 8, number of architectural registers; only 8 is supported (3-bit register fields); AW = $clog2(REG_COUNT).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept instruction this cycle.
- in_instr  in  16  instruction word.
- rf_rd_addr1  out  AW  register-file read address 1; combinational from in_instr[8:6].
- rf_rd_addr2  out  AW  register-file read address 2; combinational from in_instr[5:3].
- rf_rd_data1  in  REG_WIDTH  async read data 1.
- rf_rd_data2  in  REG_WIDTH  async read data 2.
- out_valid  out  1  issue packet valid.
- out_ready  in  1  execute accepts packet.
- out_op  out  4  opcode.
- out_rd  out  AW  destination register.
- out_a  out  REG_WIDTH  operand A.
- out_b  out  REG_WIDTH  operand B.
- out_we  out  1  instruction writes out_rd.
- out_illegal  out  1  opcode was undefined.
- wb_valid  in  1  writeback occurring this cycle; same cycle as register-file we.
- wb_addr  in  AW  register being written back.
- halted  out  1  HALT has issued.

Behaviour:
- Instruction format: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm8.
- Opcodes:
  - 0 NOP: no sources, no write.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rs1, rs2 -> rd.
  - 6 LDI: imm8 -> rd, no sources.
  - 7 MOV, 8 SHL, 9 SHR: rs1 -> rd.
  - F HALT: no sources, no write.
  - A-E illegal: treated as NOP with out_illegal=1.
- Scoreboard: pend[REG_COUNT-1:0], registered.
- hazard = (uses_rs1 & pend[rs1]) | (uses_rs2 & pend[rs2]) | (writes_rd & pend[rd]). hazard uses registered pend only; there is no bypass.
- in_ready = !halted & !hazard & (!out_valid | out_ready). in_ready depends combinationally on in_instr.
- Accept occurs when in_valid & in_ready. At that edge the output register loads:
  - out_op, out_rd, out_we=writes_rd, out_illegal.
  - out_a: rf_rd_data1 for source ops; imm8 zero-extended for LDI; 0 otherwise.
  - out_b: rf_rd_data2 for two-source ops; 0 otherwise.
  - out_valid=1.
- No accept and out_ready=1: out_valid<=0.
- No accept and out_valid=1, out_ready=0: packet held stable.
- Accept of a writing instruction sets pend[rd]. wb_valid clears pend[wb_addr].
- Same-register set and clear in one cycle: set wins.
- wb_valid on a register a stalled instruction is waiting on: the clear lands at that edge; the instruction issues no earlier than the following cycle (read data is then up to date). Latency from wb to dependent issue is 1 cycle.
- wb_valid for a non-pending register: no effect.
- HALT: accepted like NOP and emitted as a packet with out_we=0; halted<=1 at the accept edge. After that in_ready=0 until rst. The output drains normally.
- Throughput: 1 instruction/cycle when hazard-free and out_ready=1.
- Reset values: pend=0, out_valid=0, out_op=0, out_rd=0, out_a=0, out_b=0, out_we=0, out_illegal=0, halted=0.
- Reset mid-operation discards the held packet and all pending bits. Writebacks arriving during rst are ignored.

Decomposition:
- Shared package (cpu_pkg): opcode constants OP_NOP..OP_HALT, field bit positions, REG_WIDTH/REG_COUNT defaults, and uses_rs1/uses_rs2/writes_rd decode functions so execute/writeback share one definition.
- One natural sub-module: scoreboard. It holds pend, has set/clear ports and a three-address hazard query, and is reusable by a future multi-issue front end.

Test Plan:
- Reset, then LDI r1,0x2A with out_ready=1 -> next cycle out_valid=1, out_op=6, out_rd=1, out_a=0x2A, out_b=0, out_we=1; pend[1]=1.
- ADD r3,r1,r2 while pend[1]=1 -> in_ready=0. Pulse wb_valid with wb_addr=1 and rf holding r1=0x2A, r2=0x05 -> in_ready=1 the next cycle; packet carries out_a=0x2A, out_b=0x05.
- out_ready=0 with packet SUB r4,r5,r6 held for 3 cycles -> all out_* stable and in_ready=0. Raise out_ready with a new instruction presented -> packet replaced the same edge.
- Opcode 0xC -> packet out_illegal=1, out_we=0, no pend bit set. Then HALT -> halted=1 and in_ready=0 for 10 cycles despite in_valid=1.
- Same cycle: issue LDI r2 and wb_valid with wb_addr=2 -> pend[2]=1 afterwards (set wins). A following MOV r0,r2 stalls.
- Assert rst while out_valid=1 and pend=8'hFF -> next cycle all outputs 0, pend=0, in_ready=1.
